// File: rtl/cm_pkg.sv
// -----------------------------------------------------------------------------
// cm_pkg
// Shared definitions for the config-latch load controller:
//   - default word width / latch-word count and the derived index width
//   - the load-sequencer state encoding
//   - the checksum fold helper used when CFG_CHECKSUM_EN is defined
// -----------------------------------------------------------------------------
package cm_pkg;

    localparam int CM_WORD_W    = 32;
    localparam int CM_NUM_WORDS = 34;
    localparam int CM_IDX_W     = $clog2(CM_NUM_WORDS);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_SETUP  = 3'd2,
        ST_STROBE = 3'd3,
        ST_HOLD   = 3'd4,
        ST_CHK    = 3'd5,
        ST_FIN    = 3'd6
    } cm_state_e;

    // Running XOR checksum: the expected trailer word is the XOR of all data words.
    function automatic logic [CM_WORD_W-1:0] cm_xor_fold(
        input logic [CM_WORD_W-1:0] acc,
        input logic [CM_WORD_W-1:0] word
    );
        return acc ^ word;
    endfunction

endpackage

// File: rtl/cm_onehot_dec.sv
// -----------------------------------------------------------------------------
// cm_onehot_dec
// Turns the current latch index plus a strobe request into a one-hot enable
// vector, registered so the latch enables never glitch.
// Ports:
//   clk, reset    clock and synchronous active-high reset
//   idx           latch word index (never exceeds NUM_WORDS-1)
//   strobe        request an enable pulse for idx in the next cycle
//   en            registered one-hot (or all-zero) latch enables
// -----------------------------------------------------------------------------
module cm_onehot_dec
    import cm_pkg::*;
#(
    parameter int NUM_WORDS = CM_NUM_WORDS,
    parameter int IDX_W     = $clog2(NUM_WORDS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [IDX_W-1:0]     idx,
    input  logic                 strobe,
    output logic [NUM_WORDS-1:0] en
);

    logic [NUM_WORDS-1:0] en_s;
    logic [NUM_WORDS-1:0] en_r;

    // Decode: at most one bit set, and only while a strobe is requested.
    always_comb begin
        en_s = '0;
        for (int i = 0; i < NUM_WORDS; i++) begin
            if (strobe && (idx == IDX_W'(i))) begin
                en_s[i] = 1'b1;
            end else begin
                en_s[i] = 1'b0;
            end
        end
    end

    // Output register: enables come straight from flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            en_r <= '0;
        end else begin
            en_r <= en_s;
        end
    end

    assign en = en_r;

endmodule

// File: rtl/configs_load_ctrl_chk.sv
// -----------------------------------------------------------------------------
// configs_load_ctrl_chk
// Property checker for the latch-bank interface of configs_load_ctrl:
//   - the enables are one-hot or all-zero in every cycle
//   - the data bus does not move in any cycle where an enable is high
// Ports: clk, reset, en (latch enables), d_in (latch data bus).
// -----------------------------------------------------------------------------
module configs_load_ctrl_chk
    import cm_pkg::*;
#(
    parameter int WORD_W    = CM_WORD_W,
    parameter int NUM_WORDS = CM_NUM_WORDS
) (
    input logic                 clk,
    input logic                 reset,
    input logic [NUM_WORDS-1:0] en,
    input logic [WORD_W-1:0]    d_in
);

    a_en_onehot0 : assert property (@(posedge clk) disable iff (reset) $onehot0(en));

    a_d_in_stable : assert property (@(posedge clk) disable iff (reset) (|en) |-> $stable(d_in));

endmodule

// File: rtl/configs_load_ctrl.sv
// -----------------------------------------------------------------------------
// configs_load_ctrl
// Sequences a stream of configuration words into the level-sensitive config
// latch bank. Each accepted word is placed on the shared data bus, then the
// matching latch enable is pulsed with one cycle of setup before and one
// cycle of hold after, so latch data is stable around every enable pulse.
//
// Optional feature macro: CFG_CHECKSUM_EN
//   defined   : after the last word one extra XOR checksum word is accepted;
//               a mismatch sets the sticky io_err and suppresses io_done.
//   undefined : no checksum state or accumulator, io_err is constant 0.
//
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   io_start        pulse: begin a full load (only honoured when idle)
//   io_abort        level: drop the load and return to idle (highest priority)
//   io_word_valid   config word available from the producer
//   io_word_data    config word
//   io_word_ready   word accepted when valid && ready
//   io_d_in         registered data bus to the latch bank
//   io_configs_en   registered one-hot latch enables
//   io_busy         high in every state except idle
//   io_done         one-cycle pulse on successful completion
//   io_err          sticky checksum error, cleared by the next start
// -----------------------------------------------------------------------------
module configs_load_ctrl
    import cm_pkg::*;
#(
    parameter int WORD_W    = CM_WORD_W,
    parameter int NUM_WORDS = CM_NUM_WORDS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 io_start,
    input  logic                 io_abort,
    input  logic                 io_word_valid,
    input  logic [WORD_W-1:0]    io_word_data,
    output logic                 io_word_ready,
    output logic [WORD_W-1:0]    io_d_in,
    output logic [NUM_WORDS-1:0] io_configs_en,
    output logic                 io_busy,
    output logic                 io_done,
    output logic                 io_err
);

    localparam int               IDX_W    = $clog2(NUM_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    cm_state_e         state_r;
    cm_state_e         state_s;
    logic [IDX_W-1:0]  idx_r;
    logic [IDX_W-1:0]  idx_s;
    logic [WORD_W-1:0] d_in_r;
    logic [WORD_W-1:0] d_in_s;
    logic              ready_r;
    logic              ready_s;
    logic              busy_r;
    logic              busy_s;
    logic              done_r;
    logic              done_s;
    logic              strobe_s;
    logic              hs_s;

`ifdef CFG_CHECKSUM_EN
    logic [WORD_W-1:0] acc_r;
    logic [WORD_W-1:0] acc_s;
    logic              err_r;
    logic              err_s;
`endif

    // The ready flop always mirrors the state (WAIT/CHK), so this is a true handshake.
    assign hs_s = io_word_valid && ready_r;

    // Next-state, next-index, bus capture and registered-output next values.
    always_comb begin
        state_s  = state_r;
        idx_s    = idx_r;
        d_in_s   = d_in_r;
        strobe_s = 1'b0;
`ifdef CFG_CHECKSUM_EN
        acc_s    = acc_r;
        err_s    = err_r;
`endif
        if (io_abort) begin
            // Abort wins over start and valid; index and bus data are left as-is.
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (io_start) begin
                        state_s = ST_WAIT;
                        idx_s   = '0;
`ifdef CFG_CHECKSUM_EN
                        acc_s   = '0;
                        err_s   = 1'b0;
`endif
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (hs_s) begin
                        // The only place the latch data bus ever changes.
                        d_in_s  = io_word_data;
                        state_s = ST_SETUP;
`ifdef CFG_CHECKSUM_EN
                        acc_s   = cm_xor_fold(acc_r, io_word_data);
`endif
                    end else begin
                        state_s = ST_WAIT;
                    end
                end
                ST_SETUP: begin
                    // Request the enable now so the registered pulse lands in STROBE.
                    strobe_s = 1'b1;
                    state_s  = ST_STROBE;
                end
                ST_STROBE: begin
                    state_s = ST_HOLD;
                end
                ST_HOLD: begin
                    if (idx_r == LAST_IDX) begin
`ifdef CFG_CHECKSUM_EN
                        state_s = ST_CHK;
`else
                        state_s = ST_FIN;
`endif
                    end else begin
                        idx_s   = idx_r + IDX_W'(1);
                        state_s = ST_WAIT;
                    end
                end
                ST_CHK: begin
`ifdef CFG_CHECKSUM_EN
                    if (hs_s) begin
                        if (io_word_data == acc_r) begin
                            state_s = ST_FIN;
                        end else begin
                            err_s   = 1'b1;
                            state_s = ST_IDLE;
                        end
                    end else begin
                        state_s = ST_CHK;
                    end
`else
                    state_s = ST_IDLE;
`endif
                end
                ST_FIN: begin
                    state_s = ST_IDLE;
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end

        ready_s = (state_s == ST_WAIT) || (state_s == ST_CHK);
        busy_s  = (state_s != ST_IDLE);
        done_s  = (state_s == ST_FIN);
    end

    // State, index and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            idx_r   <= '0;
            d_in_r  <= '0;
            ready_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            d_in_r  <= d_in_s;
            ready_r <= ready_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

`ifdef CFG_CHECKSUM_EN
    // Checksum accumulator and sticky error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_r <= '0;
            err_r <= 1'b0;
        end else begin
            acc_r <= acc_s;
            err_r <= err_s;
        end
    end

    assign io_err = err_r;
`else
    assign io_err = 1'b0;
`endif

    cm_onehot_dec #(
        .NUM_WORDS (NUM_WORDS),
        .IDX_W     (IDX_W)
    ) u_dec (
        .clk    (clk),
        .reset  (reset),
        .idx    (idx_r),
        .strobe (strobe_s),
        .en     (io_configs_en)
    );

    assign io_word_ready = ready_r;
    assign io_d_in       = d_in_r;
    assign io_busy       = busy_r;
    assign io_done       = done_r;

endmodule

// File: tb/tb_configs_load_ctrl.sv
module tb_configs_load_ctrl;
    import cm_pkg::*;

    localparam int WORD_W    = 32;
    localparam int NUM_WORDS = 34;
    localparam int EV_WR     = 0;
    localparam int EV_DONE   = 1;
`ifdef CFG_CHECKSUM_EN
    localparam int DONE_LAT  = 138;
`else
    localparam int DONE_LAT  = 137;
`endif

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 io_start;
    logic                 io_abort;
    logic                 io_word_valid;
    logic [WORD_W-1:0]    io_word_data;
    logic                 io_word_ready;
    logic [WORD_W-1:0]    io_d_in;
    logic [NUM_WORDS-1:0] io_configs_en;
    logic                 io_busy;
    logic                 io_done;
    logic                 io_err;

    configs_load_ctrl #(.WORD_W(WORD_W), .NUM_WORDS(NUM_WORDS)) dut (
        .clk           (clk),
        .reset         (reset),
        .io_start      (io_start),
        .io_abort      (io_abort),
        .io_word_valid (io_word_valid),
        .io_word_data  (io_word_data),
        .io_word_ready (io_word_ready),
        .io_d_in       (io_d_in),
        .io_configs_en (io_configs_en),
        .io_busy       (io_busy),
        .io_done       (io_done),
        .io_err        (io_err)
    );

    configs_load_ctrl_chk #(.WORD_W(WORD_W), .NUM_WORDS(NUM_WORDS)) u_chk (
        .clk   (clk),
        .reset (reset),
        .en    (io_configs_en),
        .d_in  (io_d_in)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;
    bit mon_en  = 1'b0;

    typedef struct {
        int          kind;
        int          idx;
        logic [31:0] data;
        int          cyc;
    } ev_t;

    ev_t exp_q[$];

    function automatic ev_t mk_ev(input int kind, input int idx, input logic [31:0] data, input int c);
        ev_t e;
        e.kind = kind;
        e.idx  = idx;
        e.data = data;
        e.cyc  = c;
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: every enable pulse and done pulse must match the next expected event.
    always @(negedge clk) begin : monitor
        ev_t                  e;
        logic [NUM_WORDS-1:0] oh;
        if (mon_en && !reset) begin
            if (io_configs_en != '0) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_write @cycle %0d: en=0x%0h d_in=0x%0h, expected no write",
                             cyc, io_configs_en, io_d_in);
                end else begin
                    e  = exp_q.pop_front();
                    oh = '0;
                    oh[e.idx] = 1'b1;
                    check("wr_kind", 64'(EV_WR), 64'(e.kind));
                    check("wr_en", 64'(io_configs_en), 64'(oh));
                    check("wr_d_in", 64'(io_d_in), 64'(e.data));
                    check("wr_cycle", 64'(cyc), 64'(e.cyc));
                end
            end
            if (io_done) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_done @cycle %0d: done=1, expected 0", cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("done_kind", 64'(EV_DONE), 64'(e.kind));
                    check("done_cycle", 64'(cyc), 64'(e.cyc));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_d_in"},  64'(io_d_in), 64'd0);
        check({tag, "_en"},    64'(io_configs_en), 64'd0);
        check({tag, "_busy"},  64'(io_busy), 64'd0);
        check({tag, "_done"},  64'(io_done), 64'd0);
        check({tag, "_ready"}, 64'(io_word_ready), 64'd0);
        check({tag, "_err"},   64'(io_err), 64'd0);
    endtask

    // One load: words base+w, with optional stall / busy-start / abort / reset
    // injected at a given word (-1 disables each).
    task automatic run_load(input logic [31:0] base, input int stall_word, input int busy_start_word,
                            input int abort_word, input int reset_word, input bit timed, input bit bad_sum);
        int          c0;
        int          h;
        int          dc;
        bit          hs;
        logic [31:0] d;
        logic [31:0] sum;
        sum           = 32'h0000_0000;
        h             = 0;
        io_start      = 1'b1;
        io_word_valid = 1'b1;
        io_word_data  = base;
        c0            = cyc;
        step();
        io_start = 1'b0;
        check("start_busy", 64'(io_busy), 64'd1);
        check("start_err_clear", 64'(io_err), 64'd0);
        for (int w = 0; w < NUM_WORDS; w++) begin
            d = base + 32'(w);
            if (w == stall_word) begin
                io_word_valid = 1'b0;
                for (int t = 0; t < 10 && !io_word_ready; t++) step();
                repeat (5) begin
                    check("stall_ready", 64'(io_word_ready), 64'd1);
                    check("stall_en", 64'(io_configs_en), 64'd0);
                    step();
                end
            end
            io_word_valid = 1'b1;
            io_word_data  = d;
            hs = 1'b0;
            for (int t = 0; t < 20; t++) begin
                if (io_word_ready) begin
                    hs = 1'b1;
                    h  = cyc;
                    step();
                    break;
                end
                step();
            end
            if (!hs) begin
                n_tests++;
                n_fail++;
                $display("FAIL hs_timeout word %0d: got no ready in 20 cycles, expected ready", w);
                io_word_valid = 1'b0;
                return;
            end
            sum = sum ^ d;
            if (timed) check("hs_cycle", 64'(h), 64'(c0 + 1 + 4 * w));
            if (w != reset_word) exp_q.push_back(mk_ev(EV_WR, w, d, h + 2));
            if (w == busy_start_word) begin
                io_start = 1'b1;
                step();
                step();
                io_start = 1'b0;
            end
            if (w == abort_word) begin
                step();
                io_abort = 1'b1;
                step();
                io_abort      = 1'b0;
                io_word_valid = 1'b0;
                check("abort_en", 64'(io_configs_en), 64'd0);
                check("abort_busy", 64'(io_busy), 64'd0);
                check("abort_ready", 64'(io_word_ready), 64'd0);
                check("abort_done", 64'(io_done), 64'd0);
                check("abort_d_in_kept", 64'(io_d_in), 64'(d));
                return;
            end
            if (w == reset_word) begin
                reset = 1'b1;
                step();
                reset         = 1'b0;
                io_word_valid = 1'b0;
                check_all_zero("reset_mid");
                return;
            end
        end
`ifdef CFG_CHECKSUM_EN
        io_word_valid = 1'b1;
        io_word_data  = bad_sum ? (sum ^ 32'h0000_0001) : sum;
        for (int t = 0; t < 10 && !io_word_ready; t++) step();
        h = cyc;
        step();
        io_word_valid = 1'b0;
        if (bad_sum) begin
            check("bad_sum_err", 64'(io_err), 64'd1);
            check("bad_sum_busy", 64'(io_busy), 64'd0);
            repeat (3) step();
            check("bad_sum_err_sticky", 64'(io_err), 64'd1);
            return;
        end
        dc = h + 1;
`else
        dc = h + 4;
        if (bad_sum) check("no_checksum_err", 64'(io_err), 64'd0);
`endif
        io_word_valid = 1'b0;
        exp_q.push_back(mk_ev(EV_DONE, 0, 32'h0000_0000, dc));
        if (timed) check("done_abs_cycle", 64'(dc), 64'(c0 + DONE_LAT));
        for (int t = 0; t < 20 && cyc < dc; t++) step();
        check("fin_busy", 64'(io_busy), 64'd1);
        check("fin_err", 64'(io_err), 64'd0);
        step();
        check("post_busy", 64'(io_busy), 64'd0);
        check("post_done", 64'(io_done), 64'd0);
        check("post_ready", 64'(io_word_ready), 64'd0);
    endtask

    initial begin
        reset         = 1'b1;
        io_start      = 1'b0;
        io_abort      = 1'b0;
        io_word_valid = 1'b0;
        io_word_data  = 32'h0000_0000;
        repeat (3) step();
        check_all_zero("reset");
        reset = 1'b0;
        step();
        mon_en = 1'b1;

        // Abort beats start in the same cycle.
        io_start = 1'b1;
        io_abort = 1'b1;
        step();
        io_start = 1'b0;
        io_abort = 1'b0;
        check("abort_vs_start_busy", 64'(io_busy), 64'd0);
        check("abort_vs_start_ready", 64'(io_word_ready), 64'd0);
        step();

        // 1: full load, valid held high, absolute timing.
        run_load(32'h1000_0000, -1, -1, -1, -1, 1'b1, 1'b0);
        step();
        // 2: producer stall before word 7.
        run_load(32'h2000_0000, 7, -1, -1, -1, 1'b0, 1'b0);
        step();
        // 3: abort in STROBE of word 12, then a fresh timed load from idx 0.
        run_load(32'h3000_0000, -1, -1, 12, -1, 1'b0, 1'b0);
        step();
        run_load(32'h3100_0000, -1, -1, -1, -1, 1'b1, 1'b0);
        step();
        // 4: starts while busy at word 1, reset in SETUP of word 3, then reload.
        run_load(32'h4000_0000, -1, 1, -1, 3, 1'b0, 1'b0);
        step();
        run_load(32'h4100_0000, -1, -1, -1, -1, 1'b1, 1'b0);
        step();
`ifdef CFG_CHECKSUM_EN
        // 5: good checksum, bad checksum, then err cleared by the next start.
        run_load(32'h5000_0000, -1, -1, -1, -1, 1'b0, 1'b0);
        step();
        run_load(32'h6000_0000, -1, -1, -1, -1, 1'b0, 1'b1);
        step();
        run_load(32'h7000_0000, -1, -1, -1, -1, 1'b0, 1'b0);
        step();
`endif
        repeat (5) step();
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
